cpu_run_sequencer: RTL and testbench
====================================

// Module: cpu_run_sequencer
// PURPOSE
//  Synthesisable run controller for the cpu core. Sequences core reset and
//  bounds each run with a watchdog. Detects pass/fail from a store to a
//  "tohost" mailbox address. Sits beside cpu and data memory: it snoops the
//  store bus, drives the core's active-high reset, and reports a sticky
//  result for the sim bench or on-board LEDs.
// PARAMETERS
//  ADDR_WIDTH     32            store address width
//  DATA_WIDTH     32            store data width
//  CNT_WIDTH      32            cycle counter width
//  RESET_CYCLES   1             cycles cpu_rst_o held high per run (>=1)
//  TIMEOUT_CYCLES 25            RUN cycles before timeout; 0 = no watchdog
//  TOHOST_ADDR    32'h0000_0FF0 mailbox store address
//  PASS_CODE      32'h1         mailbox value meaning pass
//  AUTO_START     1             1: start a run right after rst_ni releases
// PORTS
//  clk_i      in   1           clock
//  rst_ni     in   1           async reset, active low
//  start_i    in   1           start/restart request (IDLE or DONE only)
//  wr_en_i    in   1           cpu data-memory write strobe
//  wr_addr_i  in   ADDR_WIDTH  cpu store address
//  wr_data_i  in   DATA_WIDTH  cpu store data
//  cpu_rst_o  out  1           reset to cpu, active high
//  running_o  out  1           high in RUN
//  done_o     out  1           run finished (sticky until next start)
//  pass_o     out  1           mailbox == PASS_CODE (valid with done_o)
//  timeout_o  out  1           watchdog expired (valid with done_o)
//  result_o   out  DATA_WIDTH  captured mailbox data
//  cycles_o   out  CNT_WIDTH   RUN cycles elapsed
// BEHAVIOUR
//  - rst_ni low (async): state IDLE, cpu_rst_o=1, all other outputs 0.
//  - States: IDLE, RESET, RUN, DONE. All outputs registered.
//  - IDLE: cpu_rst_o=1. Leave on start_i, or on the first clock edge after
//    rst_ni release if AUTO_START=1 -> RESET.
//  - Entering RESET: done/pass/timeout, result_o, cycles_o cleared; reset
//    counter loaded. cpu_rst_o=1 for exactly RESET_CYCLES cycles -> RUN.
//  - RUN: cpu_rst_o=0, running_o=1, cycles_o += 1 each edge (saturates at
//    all-ones, no wrap).
//  - Mailbox hit = wr_en_i & (wr_addr_i==TOHOST_ADDR) sampled in RUN:
//    result_o<=wr_data_i, pass_o<=(wr_data_i==PASS_CODE), -> DONE.
//    done_o rises the cycle after the hit edge (1-cycle latency).
//  - Watchdog: TIMEOUT_CYCLES!=0 and edge would make cycles_o==TIMEOUT_CYCLES
//    with no hit -> DONE, timeout_o=1, pass_o=0.
//  - Hit and timeout on same edge: hit wins, timeout_o=0.
//  - DONE: cpu_rst_o=1 (core frozen), running_o=0, done_o=1. Results and
//    cycles_o held; start_i -> RESET.
//  - start_i ignored in RESET and RUN. Stores ignored outside RUN.
//    Non-mailbox stores never affect state.
//  - rst_ni assertion mid-run aborts immediately to IDLE. No result kept.
// TESTING
//  1 AUTO_START=1, RESET_CYCLES=3, no stores -> cpu_rst_o high 3 cycles
//    after rst_ni release+1, then running_o; at 25 RUN cycles done_o=1,
//    timeout_o=1, cycles_o=25.
//  2 Store 0x1 to 0xFF0 on RUN cycle 10 -> next cycle done_o=1, pass_o=1,
//    result_o=1, cycles_o=10, cpu_rst_o=1.
//  3 Store 0x2A to 0xFF0 -> done_o=1, pass_o=0, timeout_o=0, result_o=0x2A.
//    Stores to 0xFF4 before it are ignored.
//  4 Mailbox store on RUN cycle 25 (timeout edge) -> pass_o=1, timeout_o=0.
//  5 From DONE pulse start_i -> flags/cycles_o clear, new RESET/RUN run.
//    start_i pulsed during RUN is ignored.
//  6 Drop rst_ni mid-RUN -> outputs 0, cpu_rst_o=1 at once. TIMEOUT_CYCLES=0
//    with no store -> runs past 2^8 cycles, done_o stays 0.

Source files
------------

// File: rtl/cpu_run_sequencer.sv
// Run controller for the cpu core: sequences core reset, bounds each run with a
// watchdog and latches a sticky pass/fail result from a store to the tohost mailbox.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after rst_ni, core held in reset, waiting for start
// ST_RESET | core reset asserted for RESET_CYCLES cycles, results cleared
// ST_RUN   | core running, cycles counted, mailbox snooped, watchdog armed
// ST_DONE  | result latched, core frozen until the next start
module cpu_run_sequencer #(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            CNT_WIDTH      = 32,
    parameter int unsigned            RESET_CYCLES   = 1,
    parameter int unsigned            TIMEOUT_CYCLES = 25,
    parameter logic [ADDR_WIDTH-1:0]  TOHOST_ADDR    = 'h0000_0FF0,
    parameter logic [DATA_WIDTH-1:0]  PASS_CODE      = 'h1,
    parameter bit                     AUTO_START     = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  cpu_rst_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [CNT_WIDTH-1:0]  cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_VAL   = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                   WDOG_EN  = (TIMEOUT_CYCLES != 0);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0]    cycles_q, cycles_d, cycles_inc;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic                    cpu_rst_q, running_q, done_q;
    logic                    hit, launch;

    assign hit        = wr_en_i && (wr_addr_i == TOHOST_ADDR);
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        result_d  = result_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        launch    = 1'b0;

        case (state_q)
            ST_IDLE:  launch = start_i || AUTO_START;
            ST_RESET: begin
                if (rst_cnt_q == '0) state_d = ST_RUN;
                else                 rst_cnt_d = rst_cnt_q - 1'b1;
            end
            ST_RUN: begin
                cycles_d = cycles_inc;
                // A mailbox store on the watchdog edge still counts as a result.
                if (hit) begin
                    result_d = wr_data_i;
                    pass_d   = (wr_data_i == PASS_CODE);
                    state_d  = ST_DONE;
                end else if (WDOG_EN && (cycles_inc == TO_VAL)) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE:  launch = start_i;
            default:  state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d   = ST_RESET;
            rst_cnt_d = RST_LOAD;
            cycles_d  = '0;
            result_d  = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            result_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            result_q  <= result_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            cpu_rst_q <= (state_d != ST_RUN);
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign cpu_rst_o = cpu_rst_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;
    assign result_o  = result_q;
    assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: table vectors, random runs against a
// run-level outcome model, and hand sequences for reset abort and no-watchdog mode.
module tb_cpu_run_sequencer;

    localparam int          TO     = 25;
    localparam int          RC     = 3;
    localparam int          MAXK   = 40;
    localparam logic [31:0] TOHOST = 32'h0000_0FF0;
    localparam logic [31:0] OTHER  = 32'h0000_0FF4;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n, start, start2;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;

    logic        cpu_rst, running, done, pass, timeout;
    logic [31:0] result, cycles;
    logic        cpu_rst2, running2, done2, pass2, timeout2;
    logic [31:0] result2;
    logic [7:0]  cycles2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cpu_run_sequencer #(
        .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .cpu_rst_o(cpu_rst), .running_o(running), .done_o(done), .pass_o(pass),
        .timeout_o(timeout), .result_o(result), .cycles_o(cycles)
    );

    cpu_run_sequencer #(
        .CNT_WIDTH(8), .RESET_CYCLES(2), .TIMEOUT_CYCLES(0), .AUTO_START(1'b0)
    ) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .start_i(start2),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .cpu_rst_o(cpu_rst2), .running_o(running2), .done_o(done2), .pass_o(pass2),
        .timeout_o(timeout2), .result_o(result2), .cycles_o(cycles2)
    );

    typedef struct {
        int          hit_k;
        logic [31:0] data;
        int          decoy_k;
        logic        exp_pass;
        logic        exp_to;
        logic [31:0] exp_res;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    logic        sch_en   [1:MAXK];
    logic [31:0] sch_addr [1:MAXK];
    logic [31:0] sch_data [1:MAXK];
    logic        sch_st   [1:MAXK];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic clear_sched();
        for (int k = 1; k <= MAXK; k++) begin
            sch_en[k] = 1'b0; sch_addr[k] = '0; sch_data[k] = '0; sch_st[k] = 1'b0;
        end
    endtask

    // Outcome of one run: the first mailbox store inside the watchdog window wins,
    // otherwise the run times out after TO cycles.
    function automatic void model(output int kd, output logic p, output logic t,
                                  output logic [31:0] r);
        bit found = 1'b0;
        kd = TO; p = 1'b0; t = 1'b1; r = '0;
        for (int k = 1; k <= TO; k++) begin
            if (!found && sch_en[k] && sch_addr[k] == TOHOST) begin
                found = 1'b1; kd = k; p = (sch_data[k] == 32'h1); t = 1'b0; r = sch_data[k];
            end
        end
    endfunction

    // From the current negedge, wait for RUN and count core-reset cycles seen.
    task automatic wait_run(output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (running) seen = 1'b1;
            else if (cpu_rst) n++;
        end
        if (!seen) chk("run_wait", {31'd0, running}, 32'd1);
        chk("run_start_cycles", cycles, 32'd0);
        chk("run_start_done", {31'd0, done}, 32'd0);
        chk("run_start_result", result, 32'd0);
        chk("run_start_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    endtask

    task automatic launch_from_done();
        int n;
        start = 1'b1;
        wait_run(n);
        chk("reset_len", 32'(n), 32'(RC));
    endtask

    // Applies the schedule one RUN cycle at a time until done_o appears.
    task automatic do_run(output int kd);
        kd = 0;
        for (int k = 1; k <= MAXK && kd == 0; k++) begin
            wr_en = sch_en[k]; wr_addr = sch_addr[k]; wr_data = sch_data[k]; start = sch_st[k];
            @(negedge clk);
            if (done) kd = k;
            else if (cycles !== 32'(k) || !running || cpu_rst)
                chk("run_progress", cycles, 32'(k));
        end
        wr_en = 1'b0; start = 1'b0;
        if (kd == 0) chk("done_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic check_done(input string tag, input int kd, input int exp_kd,
                              input logic ep, input logic et, input logic [31:0] er);
        chk({tag, "_latency"}, 32'(kd), 32'(exp_kd));
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, ep});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, et});
        chk({tag, "_result"}, result, er);
        chk({tag, "_cycles"}, cycles, 32'(exp_kd));
        chk({tag, "_frozen"}, {30'd0, cpu_rst, running}, 32'd2);
        // Mailbox stores while in DONE must not disturb the latched result.
        wr_en = 1'b1; wr_addr = TOHOST; wr_data = $urandom;
        repeat (2) @(negedge clk);
        wr_en = 1'b0;
        chk({tag, "_held"}, {result[29:0], done, timeout}, {er[29:0], 1'b1, et});
    endtask

    initial begin
        int kd, n, ekd;
        logic ep, et;
        logic [31:0] er;

        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        vecs[0] = '{0,  32'h0,         0, 1'b0, 1'b1, 32'h0,         25};
        vecs[1] = '{10, 32'h1,         0, 1'b1, 1'b0, 32'h1,         10};
        vecs[2] = '{6,  32'h2A,        3, 1'b0, 1'b0, 32'h2A,        6};
        vecs[3] = '{25, 32'h1,         0, 1'b1, 1'b0, 32'h1,         25};
        vecs[4] = '{1,  32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1};
        vecs[5] = '{26, 32'h1,         20, 1'b0, 1'b1, 32'h0,        25};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {27'd0, cpu_rst, running, done, pass, timeout}, 32'h10);
        chk("rst_result", result, 32'd0);
        chk("rst_cycles", cycles, 32'd0);

        rst_n = 1'b1;
        wait_run(n);
        chk("auto_reset_len", 32'(n), 32'(RC));

        for (int i = 0; i < 6; i++) begin
            if (i > 0) launch_from_done();
            clear_sched();
            if (vecs[i].hit_k > 0 && vecs[i].hit_k <= MAXK) begin
                sch_en[vecs[i].hit_k] = 1'b1; sch_addr[vecs[i].hit_k] = TOHOST;
                sch_data[vecs[i].hit_k] = vecs[i].data;
            end
            if (vecs[i].decoy_k > 0) begin
                sch_en[vecs[i].decoy_k] = 1'b1; sch_addr[vecs[i].decoy_k] = OTHER;
                sch_data[vecs[i].decoy_k] = 32'h1;
            end
            do_run(kd);
            check_done($sformatf("vec%0d", i), kd, vecs[i].exp_cyc,
                       vecs[i].exp_pass, vecs[i].exp_to, vecs[i].exp_res);
        end

        // start_i pulses during RUN must not restart the run
        launch_from_done();
        clear_sched();
        sch_st[5] = 1'b1; sch_st[12] = 1'b1;
        do_run(kd);
        check_done("start_in_run", kd, TO, 1'b0, 1'b1, 32'h0);

        for (int r = 0; r < 20; r++) begin
            launch_from_done();
            clear_sched();
            for (int k = 1; k <= MAXK; k++) begin
                sch_en[k]   = ($urandom_range(7) == 0);
                case ($urandom_range(2))
                    0: sch_addr[k] = TOHOST;
                    1: sch_addr[k] = OTHER;
                    default: sch_addr[k] = $urandom & 32'hFFFF_FFF0;
                endcase
                sch_data[k] = $urandom_range(1) ? 32'h1 : $urandom;
                sch_st[k]   = ($urandom_range(9) == 0);
            end
            model(ekd, ep, et, er);
            do_run(kd);
            check_done($sformatf("rand%0d", r), kd, ekd, ep, et, er);
        end

        // async reset mid-run aborts straight back to IDLE
        launch_from_done();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {27'd0, cpu_rst, running, done, pass, timeout}, 32'h10);
        chk("abort_cycles", cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_run(n);
        chk("abort_restart_len", 32'(n), 32'(RC));

        // no-watchdog instance: waits for start, then runs with a saturating counter
        rst_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_wait_start", {29'd0, cpu_rst2, running2, done2}, 32'h4);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = cpu_rst2 ? 1 : 0;
        for (int i = 0; i < 20 && !running2; i++) begin
            @(negedge clk);
            if (!running2 && cpu_rst2) n++;
        end
        chk("nowd_reset_len", 32'(n), 32'd2);
        repeat (300) @(negedge clk);
        chk("nowd_still_running", {30'd0, running2, done2}, 32'h2);
        chk("nowd_saturated", {24'd0, cycles2}, 32'hFF);
        wr_en = 1'b1; wr_addr = TOHOST; wr_data = 32'h1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("nowd_hit", {28'd0, done2, pass2, timeout2, cpu_rst2}, 32'hD);
        chk("nowd_hit_cycles", {24'd0, cycles2}, 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
